branch_resolve_unit: RTL
========================

# branch_resolve_unit

Parametrised, two-stage pipelined branch resolution unit for the CPU execute path. It evaluates the six RV32I conditional branch comparisons on WIDTH-bit operands and compares the outcome against the fetch-stage prediction to flag a mispredict. It uses valid/ready handshakes on both sides, supports a pipeline flush, and keeps saturating resolved and mispredict counters.

## Interface
- WIDTH, 32, operand width; must be even and ≥ 4
- TAG_W, 4, width of the opaque tag carried alongside each branch
- CNT_W, 16, width of each performance counter
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-low
- flush  input  1  kill all in-flight entries
- cnt_clear  input  1  synchronous clear of both counters
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- in_op  input  3  branch_funct3 encoding: beq=000, bne=001, blt=100, bge=101, bltu=110, bgeu=111
- in_a, in_b  input  WIDTH  operands
- in_pred_taken  input  1  predicted direction
- in_tag  input  TAG_W  tag
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_taken  output  1  resolved direction
- out_mispredict  output  1  out_taken != predicted
- out_illegal  output  1  in_op was 010 or 011
- out_tag  output  TAG_W  tag of the result
- resolved_count  output  CNT_W  results transferred
- mispredict_count  output  CNT_W  mispredicting results transferred

## Operation
- Let H = WIDTH/2.
- **Stage 1 (S1)**, registered on acceptance:
  - eq_hi, eq_lo: per-half equality.
  - lt_lo: unsigned less-than on the low halves.
  - lt_hi: less-than on the high halves. It is signed for blt and bge, computed by inverting the MSB of both operands. It is unsigned for all other ops.
  - S1 also registers op, pred_taken and tag.
- **Stage 2 (S2)**:
  - eq = eq_hi & eq_lo.
  - lt = lt_hi | (eq_hi & lt_lo).
  - taken = eq for beq, !eq for bne, lt for blt and bltu, !lt for bge and bgeu.
- **Illegal ops (010, 011)**: taken = 0, out_illegal = 1, mispredict = pred_taken.
- **Mispredict**: mispredict = taken ^ pred_taken, registered in S2.
- **Pipeline control**:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv & !flush.
  - Each stage holds its contents while stalled.
- **Accept**: a request is accepted when in_valid & in_ready. Requests presented during flush are dropped.
- **Flush**: on the next edge, s1_valid and s2_valid are cleared. An output transfer (out_valid & out_ready) in the flush cycle still completes and is counted.
- **Counters**:
  - On each transfer, resolved_count increments, and mispredict_count increments when out_mispredict is set.
  - Both counters saturate at all-ones.
  - cnt_clear has priority over increment and sets both counters to 0 at the next edge.
- **Reset**, asynchronously:
  - s1_valid, s2_valid, out_valid = 0.
  - out_taken, out_mispredict, out_illegal, out_tag = 0.
  - Counters = 0.
  - in_ready reads 1 once reset deasserts (while flush is low).
- **Reset mid-operation**: all entries are lost and no transfer is reported.
- Data registers may be left unreset, except those that drive outputs.

## Timing
- Latency: a request accepted at edge E0 gives out_valid = 1 in the cycle after edge E1 (2 cycles).
- Throughput: 1 request per cycle when out_ready is held high.
- Backpressure:
  - With out_ready = 0, the unit holds at most 2 entries.
  - in_ready falls only once both stages are full.
  - in_ready returns combinationally in the same cycle out_ready rises.
- Stability: while out_valid & !out_ready, all out_* signals are held stable.
- Counters update on the edge that ends the transfer cycle and are visible in the next cycle.
- No combinational path from in_a/in_b to any output.

## Test plan
- **Compare corners**, WIDTH=32, out_ready=1:
  - blt a=0xFFFFFFFF, b=0x00000001 -> taken=1.
  - bltu with the same operands -> taken=0.
  - bge a=0x80000000, b=0x7FFFFFFF -> taken=0.
  - beq a=b=0x12345678 -> taken=1.
  - bne with the low half differing by one bit -> taken=1.
  - Each result appears exactly 2 cycles after acceptance.
- **Mispredict and illegal**:
  - bgeu a=5, b=5, pred_taken=0 -> taken=1, mispredict=1; mispredict_count goes 0 -> 1.
  - op=010, pred_taken=1 -> taken=0, illegal=1, mispredict=1.
- **Backpressure**:
  - Stream tags 1..4 with out_ready=0 -> tags 1 and 2 are held and in_ready=0 from the cycle after the second acceptance.
  - Release out_ready -> tags 1,2,3,4 emerge in order with no loss or duplication.
- **Flush**:
  - Flush with 2 entries in flight and out_ready=1 -> the visible S2 result transfers and is counted, the S1 entry never appears, and a same-cycle in_valid is dropped.
- **Counter saturation**: CNT_W=4, 17 transfers -> resolved_count=15; then cnt_clear -> 0 at the next edge.
- **Async reset**: assert rst mid-stream between edges -> out_valid=0 and counters=0 immediately; after release, a new request resolves normally.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution: S1 splits the compare into half-width slices,
// S2 combines them, picks the branch direction and flags mispredicts.
module branch_resolve_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cnt_clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_pred_taken,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] resolved_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int H = WIDTH / 2;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic             accept;
  logic             xfer;

  logic             s1_eq_hi;
  logic             s1_eq_lo;
  logic             s1_lt_hi;
  logic             s1_lt_lo;
  logic [2:0]       s1_op;
  logic             s1_pred;
  logic [TAG_W-1:0] s1_tag;

  logic             signed_op;
  logic [H-1:0]     a_hi;
  logic [H-1:0]     b_hi;
  logic             c_eq_hi;
  logic             c_eq_lo;
  logic             c_lt_hi;
  logic             c_lt_lo;

  logic             s2_eq;
  logic             s2_lt;
  logic             s2_taken;
  logic             s2_illegal;
  logic             s2_mis;

  // Handshake and pipeline advance
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv && !flush;
  assign accept    = in_valid && in_ready;
  assign xfer      = s2_valid && out_ready;
  assign out_valid = s2_valid;

  // Flipping the high-half MSB turns the unsigned compare into a signed one
  always_comb begin
    signed_op = (in_op == OP_BLT) || (in_op == OP_BGE);
    a_hi      = {in_a[WIDTH-1] ^ signed_op, in_a[WIDTH-2:H]};
    b_hi      = {in_b[WIDTH-1] ^ signed_op, in_b[WIDTH-2:H]};
    c_eq_hi   = (in_a[WIDTH-1:H] == in_b[WIDTH-1:H]);
    c_eq_lo   = (in_a[H-1:0] == in_b[H-1:0]);
    c_lt_hi   = (a_hi < b_hi);
    c_lt_lo   = (in_a[H-1:0] < in_b[H-1:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_eq_hi <= c_eq_hi;
      s1_eq_lo <= c_eq_lo;
      s1_lt_hi <= c_lt_hi;
      s1_lt_lo <= c_lt_lo;
      s1_op    <= in_op;
      s1_pred  <= in_pred_taken;
      s1_tag   <= in_tag;
    end
  end

  always_comb begin
    s2_eq      = s1_eq_hi && s1_eq_lo;
    s2_lt      = s1_lt_hi || (s1_eq_hi && s1_lt_lo);
    s2_taken   = 1'b0;
    s2_illegal = 1'b0;
    unique case (s1_op)
      OP_BEQ:           s2_taken = s2_eq;
      OP_BNE:           s2_taken = !s2_eq;
      OP_BLT, OP_BLTU:  s2_taken = s2_lt;
      OP_BGE, OP_BGEU:  s2_taken = !s2_lt;
      default:          s2_illegal = 1'b1;
    endcase
    s2_mis = s2_taken ^ s1_pred;
  end

  // Output register holds while stalled; a flushed S1 entry is never loaded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid       <= 1'b0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      out_illegal    <= 1'b0;
      out_tag        <= '0;
    end else begin
      if (flush) begin
        s2_valid <= 1'b0;
      end else if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s2_adv && s1_valid && !flush) begin
        out_taken      <= s2_taken;
        out_mispredict <= s2_mis;
        out_illegal    <= s2_illegal;
        out_tag        <= s1_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resolved_count   <= '0;
      mispredict_count <= '0;
    end else if (cnt_clear) begin
      resolved_count   <= '0;
      mispredict_count <= '0;
    end else if (xfer) begin
      if (!(&resolved_count)) begin
        resolved_count <= resolved_count + CNT_W'(1);
      end
      if (out_mispredict && !(&mispredict_count)) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

endmodule
